// File: rtl/regfile_pkg.sv
// +-----------------------------------------------------------------------------+
// | regfile_pkg : shared widths and writeback request type for the WB arbiter   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// +-----------------------------------------------------------------------------+
// | regfile_wb_arbiter_if : datapath, B-unit and register-file write signals    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic          a_we;
  logic [AW-1:0] a_waddr;
  logic [DW-1:0] a_wdata;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_waddr;
  logic [DW-1:0] b_wdata;
  logic          issue_valid;
  logic [AW-1:0] issue_reg;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          stall;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [2**AW-1:0] pending;

  modport master (
    output a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
           issue_valid, issue_reg, rs_addr, rt_addr,
    input  b_ready, stall, rf_we, rf_waddr, rf_wdata, pending
  );

  modport slave (
    input  a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
           issue_valid, issue_reg, rs_addr, rt_addr,
    output b_ready, stall, rf_we, rf_waddr, rf_wdata, pending
  );

endinterface

`default_nettype wire

// File: rtl/wb_fifo.sv
// +-----------------------------------------------------------------------------+
// | wb_fifo : synchronous FIFO of writeback requests, power-of-two depth        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_push,
  input  wire logic i_pop,
  input  wb_req_t   i_din,
  output wb_req_t   o_dout,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t       r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// +-----------------------------------------------------------------------------+
// | regfile_wb_arbiter : shares the RF write port between datapath and B unit,  |
// | with pending scoreboard, hazard stall and B starvation guard                |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input wire logic clk,
  input wire logic rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  wb_req_t          w_push_req;
  wb_req_t          w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_hazard;
  logic             w_stall;
  logic             w_a_eff;
  logic             w_iss_eff;
  logic [2**AW-1:0] w_pending_nxt;
  logic [2**AW-1:0] r_pending;
  logic [WW-1:0]    r_wait_cnt;
  logic             r_starve;

  assign w_hazard = r_pending[bus.rs_addr] | r_pending[bus.rt_addr]
                  | (bus.a_we & r_pending[bus.a_waddr])
                  | (bus.issue_valid & r_pending[bus.issue_reg]);

  assign w_stall   = rst_n & (r_starve | w_hazard);
  assign w_a_eff   = rst_n & bus.a_we & ~w_stall & (bus.a_waddr != REG_ZERO);
  assign w_iss_eff = rst_n & bus.issue_valid & ~w_stall;
  // B drains whenever the datapath is not writing, including every stall cycle.
  assign w_pop     = rst_n & ~w_a_eff & ~w_empty;

  assign bus.b_ready = rst_n & ~w_full;
  assign w_push      = bus.b_valid & bus.b_ready;
  assign w_push_req  = '{addr: bus.b_waddr, data: bus.b_wdata};
  assign bus.stall   = w_stall;
  assign bus.pending = r_pending;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_req),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = REG_ZERO;
    bus.rf_wdata = '0;
    if (w_a_eff) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.a_waddr;
      bus.rf_wdata = bus.a_wdata;
    end else if (w_pop) begin
      bus.rf_we    = (w_head.addr != REG_ZERO);
      bus.rf_waddr = w_head.addr;
      bus.rf_wdata = w_head.data;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt[w_head.addr] = 1'b0;
    if (w_iss_eff && (bus.issue_reg != REG_ZERO)) w_pending_nxt[bus.issue_reg] = 1'b1;
    w_pending_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_wait_cnt <= '0;
      r_starve   <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (!w_empty && !w_pop) begin
        r_wait_cnt <= r_wait_cnt + WW'(1);
        r_starve   <= (r_wait_cnt == WW'(MAX_WAIT - 1));
      end else begin
        r_wait_cnt <= '0;
        r_starve   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
